sequential_multiplier_n_bit: RTL and testbench
==============================================

# sequential_multiplier_n_bit

Parametrised, multi-cycle shift-and-add multiplier producing a 2·DATA_WIDTH-bit product from two DATA_WIDTH-bit operands. Supports unsigned and two's-complement signed operation, selected per transaction, with a start/busy/done handshake. It serves area-constrained datapaths where a single-cycle array multiplier is too large. It also serves widths beyond the fixed 8-bit combinational multiplier.

## Interface
- DATA_WIDTH, 8, operand width in bits; legal range 2..32.
- Clock_In  input  1  single clock; all state updates on the rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Start_In  input  1  request a multiplication; sampled only in IDLE.
- Signed_Mode_In  input  1  1 = operands are two's complement, 0 = unsigned; sampled with Start_In.
- Data_A_In  input  DATA_WIDTH  multiplicand; sampled with Start_In.
- Data_B_In  input  DATA_WIDTH  multiplier; sampled with Start_In.
- Busy_Out  output  1  high from the cycle after an accepted start until Done_Out falls.
- Done_Out  output  1  one-cycle pulse; the result is valid from this cycle onward.
- Multiplied_Result_Out  output  2*DATA_WIDTH  product; holds its value until the next Done_Out.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- IDLE:
  - On Start_In=1, latch both operands and Signed_Mode_In, load counter = DATA_WIDTH, clear the accumulator, go to CALC.
  - On Start_In=0, remain in IDLE.
- Operand preparation at start:
  - In signed mode, latch the magnitudes |A| and |B|.
  - Set Negate_Flag = A[msb] XOR B[msb].
  - In unsigned mode, latch the operands as-is and set Negate_Flag = 0.
  - The magnitude of the most negative value (e.g. −128 for width 8) is 2^(DATA_WIDTH−1). Hold magnitudes in DATA_WIDTH bits, unsigned, so this value is not truncated.
- CALC, once per cycle:
  - If B_reg[0]=1, accumulator += A_reg << (DATA_WIDTH − counter), computed in 2·DATA_WIDTH bits with no overflow possible.
  - B_reg >>= 1 (logical) and counter −= 1.
  - When counter reaches 0 after the update, go to DONE.
  - There is no early termination: B_reg becoming zero does not shorten CALC.
- DONE:
  - Multiplied_Result_Out = Negate_Flag ? −accumulator : accumulator, in 2·DATA_WIDTH-bit two's complement.
  - Done_Out = 1 for this cycle only.
  - The FSM returns to IDLE unconditionally.
- Start_In asserted in CALC or DONE is ignored; it is not queued.
- Operand inputs change freely while Busy_Out=1 without affecting the result.
- Zero operand: the full latency still applies and the result is 0. A signed zero product is +0, because negation of 0 yields 0.

## Timing
- Reset values: state = IDLE, Busy_Out = 0, Done_Out = 0, Multiplied_Result_Out = 0, and all internal registers = 0.
- Reset asserted mid-operation:
  - Aborts immediately and asynchronously.
  - No Done_Out is produced.
  - The result is cleared to 0.
- Latency:
  - Start_In is sampled high at rising edge k.
  - Busy_Out is high from edge k to edge k+DATA_WIDTH+1.
  - Done_Out and the new Multiplied_Result_Out are registered at edge k+DATA_WIDTH+1.
  - Done_Out falls at edge k+DATA_WIDTH+2.
  - Total latency is DATA_WIDTH+1 cycles; for width 8, Done_Out follows start by 9 cycles.
- Throughput: a new Start_In is accepted no earlier than edge k+DATA_WIDTH+2, the cycle in which the FSM is back in IDLE. Back-to-back operation gives one result every DATA_WIDTH+2 cycles.
- Done_Out and Busy_Out are never both low while the FSM is in CALC. Busy_Out is high during the DONE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Unsigned maximum, width 8: A=255, B=255, mode 0 → result 0xFE01 (65025). Done_Out pulses once, exactly 9 cycles after start.
- Signed corners, width 8:
  - −128 × −128 → 0x4000.
  - −128 × 1 → 0xFF80.
  - −1 × 127 → 0xFF81.
  - 0 × −5 → 0x0000.
- Start while busy: assert Start_In with A=3, B=4, then hold Start_In high with A=9, B=9 during CALC. Only one Done_Out occurs, with result 12. Because Start_In is still high on return to IDLE, a second transaction begins and yields 81.
- Reset mid-operation: start 200×200, assert Reset_In at cycle 4 → Busy_Out, Done_Out and result go to 0 immediately. No Done_Out follows, and a subsequent 6×7 gives 42.
- Parameter sweep, DATA_WIDTH in {2, 16, 32}: random and corner operands in both modes checked against a reference model. Latency is DATA_WIDTH+1 in every case. The width-16 case includes 0xFFFF × 0xFFFF unsigned → 0xFFFE0001.

Source files
------------

// File: rtl/sequential_multiplier_n_bit.sv
// Multi-cycle shift-and-add multiplier with a start/busy/done handshake.
// Unsigned or two's-complement operation is chosen per transaction.
module sequential_multiplier_n_bit #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    Clock_In,
  input  logic                    Reset_In,
  input  logic                    Start_In,
  input  logic                    Signed_Mode_In,
  input  logic [DATA_WIDTH-1:0]   Data_A_In,
  input  logic [DATA_WIDTH-1:0]   Data_B_In,
  output logic                    Busy_Out,
  output logic                    Done_Out,
  output logic [2*DATA_WIDTH-1:0] Multiplied_Result_Out
);

  localparam int unsigned CntW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned ProdW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [ProdW-1:0]        a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [ProdW-1:0]        acc_q, acc_d;
  logic                    neg_q, neg_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [ProdW-1:0]        result_q, result_d;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b;

  // Unsigned DATA_WIDTH-bit magnitudes keep 2^(DATA_WIDTH-1) intact for the most negative value.
  always_comb begin
    mag_a = (Signed_Mode_In && Data_A_In[DATA_WIDTH-1]) ? -Data_A_In : Data_A_In;
    mag_b = (Signed_Mode_In && Data_B_In[DATA_WIDTH-1]) ? -Data_B_In : Data_B_In;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    // Busy drops together with the done pulse unless a new start is taken in that cycle.
    if (done_q) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (Start_In) begin
          a_d     = ProdW'(mag_a);
          b_d     = mag_b;
          neg_d   = Signed_Mode_In & (Data_A_In[DATA_WIDTH-1] ^ Data_B_In[DATA_WIDTH-1]);
          cnt_d   = CntW'(DATA_WIDTH);
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // a_q carries the multiplicand already shifted by (DATA_WIDTH - counter).
        if (b_q[0]) begin
          acc_d = acc_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        result_d = neg_q ? -acc_q : acc_q;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign Busy_Out              = busy_q;
  assign Done_Out              = done_q;
  assign Multiplied_Result_Out = result_q;

endmodule

// File: tb/tb_sequential_multiplier_n_bit.sv
// Directed bench for sequential_multiplier_n_bit at widths 8, 2, 16 and 32.
module tb_sequential_multiplier_n_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [31:0] a, b;
  logic        start [4];
  logic        busy  [4];
  logic        done  [4];
  logic [63:0] res   [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 16 : 32;
    logic [2*W-1:0] r;
    sequential_multiplier_n_bit #(.DATA_WIDTH(W)) u_dut (
      .Clock_In             (clk),
      .Reset_In             (rst),
      .Start_In             (start[g]),
      .Signed_Mode_In       (mode),
      .Data_A_In            (a[W-1:0]),
      .Data_B_In            (b[W-1:0]),
      .Busy_Out             (busy[g]),
      .Done_Out             (done[g]),
      .Multiplied_Result_Out(r)
    );
    assign res[g] = 64'(r);
  end

  function automatic int width_of(input int idx);
    case (idx)
      0:       return 8;
      1:       return 2;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One transaction; operand inputs are scrambled while busy to prove they were latched.
  task automatic run(input int idx, input logic [31:0] av, input logic [31:0] bv,
                     input logic md, input logic [63:0] exp, input string tag);
    int cyc;
    @(negedge clk);
    a = av; b = bv; mode = md; start[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[idx] = 1'b0; a = ~av; b = ~bv; mode = ~md;
    check_eq({tag, "_busy"}, 64'(busy[idx]), 64'd1);
    cyc = 0;
    while (!done[idx] && cyc < 200) begin
      @(posedge clk); cyc++; #1;
    end
    check_eq({tag, "_lat"}, 64'(cyc), 64'(width_of(idx) + 1));
    check_eq({tag, "_res"}, res[idx], exp);
    check_eq({tag, "_busy_done"}, 64'(busy[idx]), 64'd1);
    @(posedge clk); #1;
    check_eq({tag, "_done_fall"}, 64'(done[idx]), 64'd0);
    check_eq({tag, "_idle"}, 64'(busy[idx]), 64'd0);
  endtask

  initial begin
    int cyc;
    int seen;
    rst = 1'b1; mode = 1'b0; a = '0; b = '0;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'd0);
      check_eq($sformatf("rst_done%0d", i), 64'(done[i]), 64'd0);
      check_eq($sformatf("rst_res%0d", i), res[i], 64'd0);
    end
    rst = 1'b0;

    // Width 8 corners
    run(0, 32'hFF, 32'hFF, 1'b0, 64'hFE01, "w8_u_max");
    run(0, 32'h80, 32'h80, 1'b1, 64'h4000, "w8_s_m128sq");
    run(0, 32'h80, 32'h01, 1'b1, 64'hFF80, "w8_s_m128x1");
    run(0, 32'hFF, 32'h7F, 1'b1, 64'hFF81, "w8_s_m1x127");
    run(0, 32'h00, 32'hFB, 1'b1, 64'h0000, "w8_s_0xm5");
    run(0, 32'h05, 32'hFD, 1'b1, 64'hFFF1, "w8_s_5xm3");

    // Start held high through a busy transaction: no queueing, re-accepted in IDLE
    @(negedge clk);
    a = 32'd3; b = 32'd4; mode = 1'b0; start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'd9; b = 32'd9;
    cyc = 0;
    while (!done[0] && cyc < 200) begin
      @(posedge clk); cyc++; #1;
    end
    check_eq("swb_lat1", 64'(cyc), 64'd9);
    check_eq("swb_res1", res[0], 64'd12);
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    check_eq("swb_busy2", 64'(busy[0]), 64'd1);
    check_eq("swb_done_gap", 64'(done[0]), 64'd0);
    cyc = 0;
    while (!done[0] && cyc < 200) begin
      @(posedge clk); cyc++; #1;
    end
    check_eq("swb_lat2", 64'(cyc), 64'd9);
    check_eq("swb_res2", res[0], 64'd81);
    @(posedge clk); #1;
    check_eq("swb_idle", 64'(busy[0]), 64'd0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    a = 32'd200; b = 32'd200; mode = 1'b0; start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rmid_busy_pre", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rmid_busy", 64'(busy[0]), 64'd0);
    check_eq("rmid_done", 64'(done[0]), 64'd0);
    check_eq("rmid_res", res[0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done[0]) seen++;
    end
    check_eq("rmid_no_done", 64'(seen), 64'd0);
    run(0, 32'd6, 32'd7, 1'b0, 64'd42, "w8_after_rst");

    // Width 2
    run(1, 32'h3, 32'h3, 1'b0, 64'h9, "w2_u_max");
    run(1, 32'h2, 32'h2, 1'b1, 64'h4, "w2_s_m2sq");
    run(1, 32'h2, 32'h1, 1'b1, 64'hE, "w2_s_m2x1");
    run(1, 32'h3, 32'h1, 1'b1, 64'hF, "w2_s_m1x1");

    // Width 16
    run(2, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE0001, "w16_u_max");
    run(2, 32'hFFFF, 32'hFFFF, 1'b1, 64'h00000001, "w16_s_m1sq");
    run(2, 32'h8000, 32'h7FFF, 1'b1, 64'hC0008000, "w16_s_minxmax");

    // Width 32
    run(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "w32_u_max");
    run(3, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, "w32_s_minsq");
    run(3, 32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFFFFFFFFFE, "w32_s_m1x2");
    run(3, 32'h12345678, 32'h00000010, 1'b0, 64'h0000000123456780, "w32_u_shift");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
